// File: rtl/ifetch_if.sv
// ifetch_if: bus between the instruction fetch unit and its neighbours.
//   Instruction ROM side : imem_addr (fetch address), imem_data (combinational word)
//   Downstream side      : instr_valid/instr_ready handshake, instr_out, instr_pc
//   Redirect controls    : jump_en/jump_index, branch_en/branch_offset
//   Status               : fetch_count (instructions consumed since reset)
// The master modport is the fetch unit. The slave modport is the environment,
// which combines the ROM and the consumer.
interface ifetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        jump_en;
  logic [25:0] jump_index;
  logic        branch_en;
  logic [15:0] branch_offset;
  logic [31:0] fetch_count;

  modport master (
    output imem_addr, instr_valid, instr_out, instr_pc, fetch_count,
    input  imem_data, instr_ready, jump_en, jump_index, branch_en, branch_offset
  );

  modport slave (
    input  imem_addr, instr_valid, instr_out, instr_pc, fetch_count,
    output imem_data, instr_ready, jump_en, jump_index, branch_en, branch_offset
  );
endinterface

// File: rtl/ifetch_unit.sv
// ifetch_unit: sequential instruction fetch feeding a 2-entry {pc, instr} buffer.
//   clk   : sole clock; all state changes happen on the rising edge
//   reset : asynchronous, active-high
//   bus   : ifetch_if.master
//           - imem_addr is the pc register
//           - the ROM answers imem_data in the same cycle
//           - the buffer head is presented as instr_out/instr_pc under instr_valid
//           - jump/branch redirect from the head, flush the buffer and consume the head
//           - fetch_count counts consumed heads
// Parameter RESET_PC: first fetch address after reset.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic clk,
  input logic reset,
  ifetch_if.master bus
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] PART  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc;
  entry_t      head;   // oldest entry
  entry_t      tail;   // second entry; meaningful only in FULL
  logic [31:0] count;

  logic        valid;
  logic        pop;
  logic        redirect;
  logic        capture;
  logic [31:0] seq_pc;
  logic [31:0] br_off;
  logic [31:0] target;
  entry_t      fetched;

  assign valid    = (state == PART) || (state == FULL);
  assign pop      = valid && bus.instr_ready;
  assign redirect = valid && (bus.jump_en || bus.branch_en);
  // While FULL, a slot frees up only when the head leaves on the same edge.
  assign capture  = !redirect && ((state != FULL) || pop);

  // Redirect targets are relative to the instruction after the head.
  assign seq_pc  = head.pc + 32'd4;
  assign br_off  = {{14{bus.branch_offset[15]}}, bus.branch_offset, 2'b00};
  // The jump wins when both redirect requests are raised together.
  assign target  = bus.jump_en ? {seq_pc[31:28], bus.jump_index, 2'b00}
                               : seq_pc + br_off;
  assign fetched = '{pc: pc, instr: bus.imem_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      // A redirect consumes the head even when downstream is not ready.
      if (pop || redirect)
        count <= count + 32'd1;

      if (redirect) begin
        state <= EMPTY;
        pc    <= target;
      end else if (capture) begin
        pc <= pc + 32'd4;
        case (state)
          EMPTY: begin
            head  <= fetched;
            state <= PART;
          end
          PART: begin
            if (pop) begin
              head <= fetched;
            end else begin
              tail  <= fetched;
              state <= FULL;
            end
          end
          default: begin
            // FULL with a pop: shift the queue forward and append the new entry.
            head <= tail;
            tail <= fetched;
          end
        endcase
      end
      // There is no remaining case that changes state. Without a capture or a
      // redirect the buffer is FULL with no pop, so everything holds.
    end
  end

  assign bus.imem_addr   = pc;
  assign bus.instr_valid = valid;
  assign bus.instr_out   = head.instr;
  assign bus.instr_pc    = head.pc;
  assign bus.fetch_count = count;

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

  logic clk = 1'b0;
  logic reset;
  logic rst2;

  always #5 clk = ~clk;

  ifetch_if bus ();
  ifetch_if bus2 ();

  ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .bus(bus.master));

  ifetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .reset(rst2), .bus(bus2.master));

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h0) return 32'h8C03_0008;
    if (a == 32'h4) return 32'h2063_0006;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  always_comb bus.imem_data  = rom(bus.imem_addr);
  always_comb bus2.imem_data = rom(bus2.imem_addr);

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // Scoreboard: pcs of heads expected to be consumed, in order.
  logic [31:0] sb_q[$];
  logic [31:0] exp_count;
  logic [31:0] exp_pc;

  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
      exp_count = 0;
    end else begin
      chk("fetch_count", bus.fetch_count, exp_count);
      if (bus.instr_valid && (bus.instr_ready || bus.jump_en || bus.branch_en)) begin
        chk("sb_depth", {31'd0, sb_q.size() != 0}, 32'd1);
        if (sb_q.size() != 0) begin
          exp_pc = sb_q.pop_front();
          chk("head_pc", bus.instr_pc, exp_pc);
          chk("head_instr", bus.instr_out, rom(exp_pc));
        end
        exp_count = exp_count + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.instr_ready = 1'b0;
    bus.jump_en = 1'b0;
    bus.branch_en = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Stream k heads (pcs 0..4(k-1)) so that the head then shows pc 4k.
  task automatic run_to_head(input int k);
    for (int i = 0; i < k; i++) sb_q.push_back(32'(4 * i));
    bus.instr_ready = 1'b1;
    repeat (k + 1) tick();
    bus.instr_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    rst2  = 1'b1;
    bus.instr_ready = 1'b0;
    bus.jump_en = 1'b0;
    bus.jump_index = '0;
    bus.branch_en = 1'b0;
    bus.branch_offset = '0;
    bus2.instr_ready = 1'b1;
    bus2.jump_en = 1'b0;
    bus2.jump_index = '0;
    bus2.branch_en = 1'b0;
    bus2.branch_offset = '0;

    // The outputs while reset is held.
    tick();
    tick();
    chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_count", bus.fetch_count, 32'h0);
    chk("rst_instr", bus.instr_out, 32'h0);
    chk("rst_pc", bus.instr_pc, 32'h0);

    // Basic streaming with ready held high.
    reset = 1'b0;
    sb_q.push_back(32'h0);
    sb_q.push_back(32'h4);
    bus.instr_ready = 1'b1;
    chk("t1_addr0", bus.imem_addr, 32'h0);
    chk("t1_valid0", {31'd0, bus.instr_valid}, 32'd0);
    tick();
    chk("t1_addr1", bus.imem_addr, 32'h4);
    chk("t1_head0", bus.instr_pc, 32'h0);
    tick();
    chk("t1_addr2", bus.imem_addr, 32'h8);
    tick();
    bus.instr_ready = 1'b0;
    chk("t1_count", bus.fetch_count, 32'd2);

    // Stall until FULL, then release.
    do_reset();
    repeat (5) tick();
    chk("t2_valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("t2_head", bus.instr_pc, 32'h0);
    chk("t2_addr_hold", bus.imem_addr, 32'h8);
    sb_q.push_back(32'h0);
    sb_q.push_back(32'h4);
    sb_q.push_back(32'h8);
    bus.instr_ready = 1'b1;
    tick();
    chk("t2_nogap1", {31'd0, bus.instr_valid}, 32'd1);
    tick();
    chk("t2_nogap2", {31'd0, bus.instr_valid}, 32'd1);
    tick();
    bus.instr_ready = 1'b0;
    chk("t2_count", bus.fetch_count, 32'd3);

    // Jump redirect from head pc 0x10.
    do_reset();
    run_to_head(4);
    chk("t3_head", bus.instr_pc, 32'h10);
    sb_q.push_back(32'h10);
    bus.jump_en = 1'b1;
    bus.jump_index = 26'h2;
    tick();
    bus.jump_en = 1'b0;
    chk("t3_addr", bus.imem_addr, 32'h8);
    chk("t3_empty", {31'd0, bus.instr_valid}, 32'd0);
    chk("t3_count", bus.fetch_count, 32'd5);
    tick();
    chk("t3_refill", bus.instr_pc, 32'h8);

    // Branch back by two words, then jump and branch together.
    do_reset();
    run_to_head(8);
    chk("t4_head", bus.instr_pc, 32'h20);
    sb_q.push_back(32'h20);
    bus.branch_en = 1'b1;
    bus.branch_offset = 16'hFFFE;
    tick();
    bus.branch_en = 1'b0;
    chk("t4_br_addr", bus.imem_addr, 32'h1C);
    chk("t4_br_count", bus.fetch_count, 32'd9);
    tick();
    chk("t4_head2", bus.instr_pc, 32'h1C);
    sb_q.push_back(32'h1C);
    bus.jump_en = 1'b1;
    bus.jump_index = 26'h0;
    bus.branch_en = 1'b1;
    tick();
    bus.jump_en = 1'b0;
    bus.branch_en = 1'b0;
    chk("t4_prio_addr", bus.imem_addr, 32'h0);
    chk("t4_prio_count", bus.fetch_count, 32'd10);

    // An asynchronous reset while FULL.
    do_reset();
    repeat (3) tick();
    chk("t5_full_valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("t5_full_addr", bus.imem_addr, 32'h8);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("t5_addr", bus.imem_addr, 32'h0);
    chk("t5_count", bus.fetch_count, 32'h0);
    chk("t5_pc", bus.instr_pc, 32'h0);

    // pc wraps from a RESET_PC near the top of the address space.
    tick();
    chk("t6_rst_addr", bus2.imem_addr, 32'hFFFF_FFF8);
    rst2 = 1'b0;
    tick();
    chk("t6_addr1", bus2.imem_addr, 32'hFFFF_FFFC);
    chk("t6_head1", bus2.instr_pc, 32'hFFFF_FFF8);
    tick();
    chk("t6_addr2", bus2.imem_addr, 32'h0000_0000);
    chk("t6_head2", bus2.instr_pc, 32'hFFFF_FFFC);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
